// File: rtl/mac_tx_crc_calculate.sv
// Ethernet MAC TX framer: preamble/SFD, body, optional pad, FCS, IFG.
// Ports: logic_clk/logic_rst (async high); mac_rnet_* byte stream in
// (data/valid/ready/last); mac_tphy_* registered PHY byte out
// (data/valid/err). Optional padding: define MAC_TX_PAD_EN.
module mac_tx_crc_calculate #(
    parameter logic [63:0] PREAMBLE_REG = 64'h5555_5555_5555_55D5,
    parameter int          IFG_BYTES    = 12,
    parameter int          MIN_BODY     = 60
) (
    input  logic       logic_clk,
    input  logic       logic_rst,
    input  logic [7:0] mac_rnet_data_in,
    input  logic       mac_rnet_valid_in,
    output logic       mac_rnet_ready_out,
    input  logic       mac_rnet_last_in,
    output logic [7:0] mac_tphy_data_out,
    output logic       mac_tphy_valid_out,
    output logic       mac_tphy_err_out
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
`ifdef MAC_TX_PAD_EN
        PAD,
`endif
        FCS,
        IFG,
        DISCARD
    } state_t;

    // The IDLE cycle that follows IFG is itself one low output cycle,
    // so IFG holds one cycle fewer to give exactly IFG_BYTES low cycles.
    localparam int IFG_CYC = (IFG_BYTES > 1) ? IFG_BYTES - 1 : 1;
    localparam logic [15:0] IFG_END = 16'(IFG_CYC - 1);

`ifdef MAC_TX_PAD_EN
    localparam logic [10:0] MIN_LEN = 11'(MIN_BODY);
`endif

    state_t      state;
    state_t      state_n;
    logic [15:0] step;
    logic [15:0] step_n;
    logic [31:0] crc;
    logic [31:0] crc_n;
    logic [7:0]  data_q;
    logic [7:0]  data_d;
    logic        valid_q;
    logic        valid_d;
    logic        err_q;
    logic        err_d;
    logic [63:0] pre_sh;
    logic [31:0] fcs_sh;
    logic        xfer;

`ifdef MAC_TX_PAD_EN
    logic [10:0] body_cnt;
    logic [10:0] body_n;
    logic [10:0] body_inc;
`endif

    // Reflected CRC-32, one byte per call.
    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign mac_rnet_ready_out = (state == DATA) || (state == DISCARD);
    assign xfer = mac_rnet_valid_in && mac_rnet_ready_out;

    assign pre_sh = PREAMBLE_REG << {step[2:0], 3'b000};
    assign fcs_sh = (~crc) >> {step[1:0], 3'b000};

`ifdef MAC_TX_PAD_EN
    assign body_inc = (body_cnt == 11'h7FF) ? body_cnt : body_cnt + 11'd1;
`endif

    always_comb begin
        state_n = state;
        step_n  = step;
        crc_n   = crc;
        data_d  = 8'h00;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef MAC_TX_PAD_EN
        body_n  = body_cnt;
`endif
        case (state)
            IDLE: begin
                if (mac_rnet_valid_in) begin
                    state_n = PRE;
                    step_n  = 16'd0;
                    crc_n   = 32'hFFFF_FFFF;
`ifdef MAC_TX_PAD_EN
                    body_n  = 11'd0;
`endif
                end
            end
            PRE: begin
                valid_d = 1'b1;
                data_d  = pre_sh[63:56];
                if (step[2:0] == 3'd7) begin
                    state_n = DATA;
                    step_n  = 16'd0;
                end else begin
                    step_n = step + 16'd1;
                end
            end
            DATA: begin
                valid_d = 1'b1;
                if (mac_rnet_valid_in) begin
                    data_d = mac_rnet_data_in;
                    crc_n  = crc_byte(crc, mac_rnet_data_in);
`ifdef MAC_TX_PAD_EN
                    body_n = body_inc;
`endif
                    if (mac_rnet_last_in) begin
                        step_n  = 16'd0;
                        state_n = FCS;
`ifdef MAC_TX_PAD_EN
                        if (body_inc < MIN_LEN) state_n = PAD;
`endif
                    end
                end else begin
                    // Underrun: flag the byte and drop the rest.
                    err_d   = 1'b1;
                    state_n = DISCARD;
                end
            end
`ifdef MAC_TX_PAD_EN
            PAD: begin
                valid_d = 1'b1;
                crc_n   = crc_byte(crc, 8'h00);
                body_n  = body_inc;
                if (body_inc >= MIN_LEN) begin
                    state_n = FCS;
                    step_n  = 16'd0;
                end
            end
`endif
            FCS: begin
                valid_d = 1'b1;
                data_d  = fcs_sh[7:0];
                if (step[1:0] == 2'd3) begin
                    state_n = IFG;
                    step_n  = 16'd0;
                end else begin
                    step_n = step + 16'd1;
                end
            end
            IFG: begin
                if (step == IFG_END) begin
                    state_n = IDLE;
                end else begin
                    step_n = step + 16'd1;
                end
            end
            DISCARD: begin
                if (xfer && mac_rnet_last_in) begin
                    state_n = IFG;
                    step_n  = 16'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state    <= IDLE;
            step     <= 16'd0;
            crc      <= 32'hFFFF_FFFF;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef MAC_TX_PAD_EN
            body_cnt <= 11'd0;
`endif
        end else begin
            state    <= state_n;
            step     <= step_n;
            crc      <= crc_n;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef MAC_TX_PAD_EN
            body_cnt <= body_n;
`endif
        end
    end

    assign mac_tphy_data_out  = data_q;
    assign mac_tphy_valid_out = valid_q;
    assign mac_tphy_err_out   = err_q;

endmodule

// File: tb/tb_mac_tx_crc_calculate.sv
// Self-checking bench for mac_tx_crc_calculate.
// Output trace is compared against a frame model built in the bench.
module tb_mac_tx_crc_calculate;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic       lin;
    logic       rdy;
    logic [7:0] dout;
    logic       vout;
    logic       eout;

    always #5 clk = ~clk;

    mac_tx_crc_calculate dut (
        .logic_clk          (clk),
        .logic_rst          (rst),
        .mac_rnet_data_in   (din),
        .mac_rnet_valid_in  (vin),
        .mac_rnet_ready_out (rdy),
        .mac_rnet_last_in   (lin),
        .mac_tphy_data_out  (dout),
        .mac_tphy_valid_out (vout),
        .mac_tphy_err_out   (eout)
    );

    typedef struct packed {
        logic       v;
        logic       e;
        logic [7:0] d;
    } smp_t;
    typedef smp_t       sq_t[$];
    typedef logic [7:0] bq_t[$];

    localparam logic [63:0] PRE = 64'h5555_5555_5555_55D5;
`ifdef MAC_TX_PAD_EN
    localparam int MINB = 60;
`else
    localparam int MINB = 0;
`endif

    sq_t log_q;
    bit  cap = 1'b0;
    int  errors = 0;
    int  checks = 0;

    always @(negedge clk) begin
        if (cap) log_q.push_back(smp_t'({vout, eout, dout}));
    end

    // MSB-first division with preset, then complement and bit reversal.
    function automatic logic [31:0] ref_crc(input bq_t m);
        logic [31:0] r;
        logic [31:0] v;
        logic [31:0] o;
        logic        fb;
        r = 32'hFFFF_FFFF;
        foreach (m[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[31] ^ m[i][b];
                r  = {r[30:0], 1'b0};
                if (fb) r = r ^ 32'h04C1_1DB7;
            end
        end
        v = ~r;
        for (int k = 0; k < 32; k++) o[k] = v[31-k];
        return o;
    endfunction

    function automatic smp_t mk(input logic v, input logic e,
                                input logic [7:0] d);
        return smp_t'({v, e, d});
    endfunction

    // Expected PHY trace for one frame; ur >= 0 models an underrun.
    function automatic sq_t build(input bq_t body, input int ur);
        sq_t         q;
        bq_t         b;
        logic [63:0] p;
        logic [31:0] f;
        p = PRE;
        for (int i = 0; i < 8; i++) q.push_back(mk(1, 0, p[63-8*i -: 8]));
        if (ur >= 0) begin
            for (int i = 0; i < ur; i++) q.push_back(mk(1, 0, body[i]));
            q.push_back(mk(1, 1, 8'h00));
            return q;
        end
        b = body;
        while (b.size() < MINB) b.push_back(8'h00);
        foreach (b[i]) q.push_back(mk(1, 0, b[i]));
        f = ref_crc(b);
        for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, f[8*i +: 8]));
        for (int i = 0; i < 12; i++) q.push_back(mk(0, 0, 8'h00));
        return q;
    endfunction

    function automatic int first_valid();
        foreach (log_q[i]) if (log_q[i].v) return i;
        return -1;
    endfunction

    function automatic bq_t rand_body(input int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    task automatic wait_xfer();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rdy && t < 300);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout ready=%b want=1", rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bq_t body, input int ur, input bit hold);
        for (int i = 0; i < body.size(); i++) begin
            if (i == ur && ur > 0) begin
                vin = 1'b0;
                lin = 1'b0;
                @(posedge clk);
                #1;
            end
            din = body[i];
            vin = 1'b1;
            lin = (i == body.size() - 1);
            wait_xfer();
        end
        if (!hold) begin
            vin = 1'b0;
            lin = 1'b0;
        end
    endtask

    task automatic start_cap();
        log_q.delete();
        cap = 1'b1;
    endtask

    task automatic stop_cap(input int n);
        repeat (n) @(posedge clk);
        #1;
        cap = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 8'h00;
        vin = 1'b0;
        lin = 1'b0;
        #1;
        checks++;
        if ({vout, eout, dout, rdy} !== 11'h0) begin
            errors++;
            $display("FAIL reset_hold got=%h want=0", {vout, eout, dout, rdy});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({vout, eout, dout, rdy} !== 11'h0) begin
                errors++;
                $display("FAIL reset_idle[%0d] got=%h want=0", i,
                         {vout, eout, dout, rdy});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_crc_vector();
        bq_t  b;
        sq_t  e;
        smp_t g;
        int   f;
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        e = build(b, -1);
        start_cap();
        drive(b, -1, 0);
        stop_cap(25);
        f = first_valid();
        checks++;
        if (f !== 2) begin
            errors++;
            $display("FAIL crc_latency got=%0d want=2", f);
        end
        for (int i = 0; i < e.size(); i++) begin
            g = 'x;
            if (f >= 0 && f + i < log_q.size()) g = log_q[f+i];
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL crc_vec[%0d] got=%h want=%h", i, g, e[i]);
            end
        end
`ifndef MAC_TX_PAD_EN
        begin
            logic [31:0] want;
            logic [31:0] got;
            want = 32'hCBF4_3926;
            got  = 'x;
            if (f >= 0 && f + 20 < log_q.size()) begin
                for (int i = 0; i < 4; i++) got[8*i +: 8] = log_q[f+17+i].d;
            end
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL crc_const got=%h want=%h", got, want);
            end
        end
`endif
    endtask

    task automatic test_random_frames();
        bq_t  b;
        sq_t  e;
        smp_t g;
        int   f;
        int   n;
        for (int k = 0; k < 8; k++) begin
            n = (k == 0) ? 1 : (k == 1) ? 42 : $urandom_range(2, 100);
            b = rand_body(n);
            e = build(b, -1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            start_cap();
            drive(b, -1, 0);
            stop_cap(25);
            f = first_valid();
            for (int i = 0; i < e.size(); i++) begin
                g = 'x;
                if (f >= 0 && f + i < log_q.size()) g = log_q[f+i];
                checks++;
                if (g !== e[i]) begin
                    errors++;
                    $display("FAIL rand%0d_n%0d[%0d] got=%h want=%h",
                             k, n, i, g, e[i]);
                end
            end
        end
    endtask

`ifdef MAC_TX_PAD_EN
    task automatic test_padding();
        bq_t  b;
        sq_t  e;
        smp_t g;
        int   f;
        int   run;
        b = rand_body(42);
        e = build(b, -1);
        start_cap();
        drive(b, -1, 0);
        stop_cap(45);
        f = first_valid();
        for (int i = 0; i < e.size(); i++) begin
            g = 'x;
            if (f >= 0 && f + i < log_q.size()) g = log_q[f+i];
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL pad[%0d] got=%h want=%h", i, g, e[i]);
            end
        end
        run = 0;
        if (f >= 0) begin
            for (int i = f; i < log_q.size() && log_q[i].v; i++) run++;
        end
        checks++;
        if (run !== 72) begin
            errors++;
            $display("FAIL pad_len got=%0d want=72", run);
        end
    endtask
`endif

    task automatic test_underrun();
        bq_t  b;
        sq_t  e;
        smp_t g;
        int   f;
        int   bad;
        b = rand_body(30);
        e = build(b, 10);
        start_cap();
        drive(b, 10, 0);
        stop_cap(25);
        f = first_valid();
        for (int i = 0; i < e.size(); i++) begin
            g = 'x;
            if (f >= 0 && f + i < log_q.size()) g = log_q[f+i];
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL underrun[%0d] got=%h want=%h", i, g, e[i]);
            end
        end
        bad = 0;
        if (f >= 0) begin
            for (int i = f + e.size(); i < log_q.size(); i++) begin
                if (log_q[i].v !== 1'b0 || log_q[i].e !== 1'b0) bad++;
            end
        end
        checks++;
        if (f < 0 || bad != 0) begin
            errors++;
            $display("FAIL underrun_tail got=%0d busy want=0", bad);
        end
    endtask

    task automatic test_back_to_back();
        bq_t  b1;
        bq_t  b2;
        sq_t  e;
        sq_t  e2;
        smp_t g;
        int   f;
        b1 = rand_body(64);
        b2 = rand_body(64);
        e  = build(b1, -1);
        e2 = build(b2, -1);
        foreach (e2[i]) e.push_back(e2[i]);
        start_cap();
        drive(b1, -1, 1);
        drive(b2, -1, 0);
        stop_cap(25);
        f = first_valid();
        for (int i = 0; i < e.size(); i++) begin
            g = 'x;
            if (f >= 0 && f + i < log_q.size()) g = log_q[f+i];
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, g, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fcs();
        bq_t  b;
        sq_t  e;
        smp_t g;
        int   f;
        int   cnt;
        int   tgt;
        int   t;
        b   = rand_body(20);
        e   = build(b, -1);
        tgt = 8 + ((b.size() < MINB) ? MINB : b.size()) + 2;
        start_cap();
        drive(b, -1, 0);
        t = 0;
        cnt = 0;
        while (cnt < tgt && t < 200) begin
            @(negedge clk);
            #1;
            t++;
            cnt = 0;
            foreach (log_q[i]) if (log_q[i].v) cnt++;
        end
        cap = 1'b0;
        g = 'x;
        if (log_q.size() > 0) g = log_q[log_q.size()-1];
        checks++;
        if (cnt != tgt || g !== e[tgt-1]) begin
            errors++;
            $display("FAIL rst_fcs2 got=%h want=%h", g, e[tgt-1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({vout, eout, dout, rdy} !== 11'h0) begin
            errors++;
            $display("FAIL rst_mid got=%h want=0", {vout, eout, dout, rdy});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        b = rand_body(33);
        e = build(b, -1);
        start_cap();
        drive(b, -1, 0);
        stop_cap(45);
        f = first_valid();
        for (int i = 0; i < e.size(); i++) begin
            g = 'x;
            if (f >= 0 && f + i < log_q.size()) g = log_q[f+i];
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL rst_next[%0d] got=%h want=%h", i, g, e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_crc_vector();
        test_random_frames();
`ifdef MAC_TX_PAD_EN
        test_padding();
`endif
        test_underrun();
        test_back_to_back();
        test_reset_mid_fcs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
